// File: rtl/operand_stage.sv
// Operand fetch stage: reads the register file, forwards EX/MEM results, detects
// RAW/load-use hazards and registers the operand bundle handed to EX.

module operand_sel #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_fwd_ok,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_rd_we,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] op
);
  // x0 is hardwired zero, so it never takes a forwarded value.
  always_comb begin
    op = rf_data;
    if (addr == '0)
      op = '0;
    else if (ex_fwd_ok && ex_rd == addr)
      op = ex_data;
    else if (mem_rd_we && mem_rd == addr)
      op = mem_data;
  end
endmodule

module operand_stage #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NUM_SRC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [AW-1:0]   in_rs1_addr,
  input  logic [AW-1:0]   in_rs2_addr,
  input  logic [AW-1:0]   in_rd_addr,
  input  logic            in_rd_we,
  input  logic            in_is_load,
  output logic [AW-1:0]   rf_rs1_addr,
  output logic [AW-1:0]   rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  input  logic            ex_rd_we,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ex_data_ok,
  input  logic            mem_rd_we,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd_addr,
  output logic            out_rd_we,
  output logic            out_is_load,
  output logic [15:0]     stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rd;
    logic            rd_we;
    logic            is_load;
  } out_t;

  out_t        out_q;
  logic        vld_q;
  logic [15:0] stall_q;

  logic [NUM_SRC-1:0][AW-1:0]   src_addr;
  logic [NUM_SRC-1:0][XLEN-1:0] src_rf;
  logic [NUM_SRC-1:0][XLEN-1:0] src_op;

  logic ex_fwd_ok;
  logic hit_out, hit_ex;
  logic stall, advance, capture;

  assign rf_rs1_addr = in_rs1_addr;
  assign rf_rs2_addr = in_rs2_addr;

  assign src_addr = {in_rs2_addr, in_rs1_addr};
  assign src_rf   = {rf_rs2, rf_rs1};

  function automatic logic src_match(input logic v, input logic [AW-1:0] r,
                                     input logic [AW-1:0] a, input logic [AW-1:0] b);
    return v && (r != '0) && (r == a || r == b);
  endfunction

  // An un-accepted producer still in this stage, or a load in EX whose data is
  // not ready, cannot be forwarded yet.
  assign hit_out = vld_q && out_q.rd_we &&
                   src_match(in_valid, out_q.rd, in_rs1_addr, in_rs2_addr);
  assign hit_ex  = ex_rd_we && !ex_data_ok &&
                   src_match(in_valid, ex_rd, in_rs1_addr, in_rs2_addr);
  assign stall   = hit_out || hit_ex;

  assign ex_fwd_ok = ex_rd_we && ex_data_ok;

  genvar g;
  for (g = 0; g < NUM_SRC; g++) begin : g_src
    operand_sel #(.XLEN(XLEN), .AW(AW)) u_sel (
      .addr      (src_addr[g]),
      .rf_data   (src_rf[g]),
      .ex_fwd_ok (ex_fwd_ok),
      .ex_rd     (ex_rd),
      .ex_data   (ex_data),
      .mem_rd_we (mem_rd_we),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .op        (src_op[g])
    );
  end

  assign advance  = out_ready || !vld_q;
  assign in_ready = clk_en && !flush && !stall && advance;
  assign capture  = in_valid && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      out_q   <= '0;
      stall_q <= '0;
    end else if (clk_en) begin
      if (flush) begin
        vld_q <= 1'b0;
      end else if (advance) begin
        vld_q <= capture;
        if (capture) begin
          out_q.pc      <= in_pc;
          out_q.op1     <= src_op[0];
          out_q.op2     <= src_op[1];
          out_q.imm     <= in_imm;
          out_q.rd      <= in_rd_addr;
          out_q.rd_we   <= in_rd_we;
          out_q.is_load <= in_is_load;
        end
      end
      if (in_valid && stall && !flush && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign out_valid   = vld_q;
  assign out_pc      = out_q.pc;
  assign out_op1     = out_q.op1;
  assign out_op2     = out_q.op2;
  assign out_imm     = out_q.imm;
  assign out_rd_addr = out_q.rd;
  assign out_rd_we   = out_q.rd_we;
  assign out_is_load = out_q.is_load;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: expected bundles go into a queue when issued,
// a negedge monitor pops and compares each bundle EX accepts.

module tb_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n, clk_en, in_valid, in_ready;
  logic [31:0] in_pc, in_imm, rf_rs1, rf_rs2, ex_data, mem_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, rf_rs1_addr, rf_rs2_addr, ex_rd, mem_rd;
  logic        in_rd_we, in_is_load, ex_rd_we, ex_data_ok, mem_rd_we, flush;
  logic        out_valid, out_ready, out_rd_we, out_is_load;
  logic [31:0] out_pc, out_op1, out_op2, out_imm;
  logic [4:0]  out_rd_addr;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic        we, ld;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   w;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .ex_rd_we(ex_rd_we), .ex_rd(ex_rd), .ex_data(ex_data), .ex_data_ok(ex_data_ok),
    .mem_rd_we(mem_rd_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait (bounded) for acceptance, then drop in_valid.
  task automatic send(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic [31:0] imm, input logic [31:0] rf1, input logic [31:0] rf2,
                      input logic [31:0] e1, input logic [31:0] e2, output int waited);
    exp_t e;
    logic ok;
    in_valid = 1'b1; in_pc = pc; in_rs1_addr = r1; in_rs2_addr = r2;
    in_rd_addr = rd; in_rd_we = we; in_is_load = ld; in_imm = imm;
    rf_rs1 = rf1; rf_rs2 = rf2;
    e.pc = pc; e.op1 = e1; e.op2 = e2; e.imm = imm; e.rd = rd; e.we = we; e.ld = ld;
    q.push_back(e);
    waited = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        waited++;
        @(posedge clk);
        #1;
      end
    end
    chk("send_accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && clk_en && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out pc=%h op1=%h op2=%h", out_pc, out_op1, out_op2);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_pc !== e.pc || out_op1 !== e.op1 || out_op2 !== e.op2 || out_imm !== e.imm ||
            out_rd_addr !== e.rd || out_rd_we !== e.we || out_is_load !== e.ld) begin
          errors++;
          $display("FAIL out_bundle got pc=%h op1=%h op2=%h imm=%h rd=%0d we=%b ld=%b want pc=%h op1=%h op2=%h imm=%h rd=%0d we=%b ld=%b",
                   out_pc, out_op1, out_op2, out_imm, out_rd_addr, out_rd_we, out_is_load,
                   e.pc, e.op1, e.op2, e.imm, e.rd, e.we, e.ld);
        end
      end
    end
  end

  initial begin
    clk_en = 1'b1; in_valid = 1'b0; in_pc = '0; in_imm = '0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0; in_rd_we = 1'b0; in_is_load = 1'b0;
    rf_rs1 = '0; rf_rs2 = '0; ex_rd_we = 1'b0; ex_rd = '0; ex_data = '0; ex_data_ok = 1'b1;
    mem_rd_we = 1'b0; mem_rd = '0; mem_data = '0; flush = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_rd_we", {31'd0, out_rd_we}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_rs1_addr = 5'd9; in_rs2_addr = 5'd17;
    #1;
    chk("rf_rs1_addr", {27'd0, rf_rs1_addr}, 32'd9);
    chk("rf_rs2_addr", {27'd0, rf_rs2_addr}, 32'd17);
    tick();

    // plain capture
    send(32'h100, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'h5, 32'h11, 32'h22, 32'h11, 32'h22, w);
    chk("plain_no_stall", w, 32'd0);
    tick();

    // EX beats MEM, then MEM beats RF
    ex_rd_we = 1'b1; ex_rd = 5'd5; ex_data_ok = 1'b1; ex_data = 32'hA;
    mem_rd_we = 1'b1; mem_rd = 5'd5; mem_data = 32'hB;
    send(32'h104, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'hDEAD, 32'h55, 32'hA, 32'h0, w);
    ex_rd_we = 1'b0;
    send(32'h108, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'hDEAD, 32'h55, 32'hB, 32'h0, w);
    mem_rd_we = 1'b0;
    tick();

    // x0 ignores an EX writer, even one whose data is not ready
    ex_rd_we = 1'b1; ex_rd = 5'd0; ex_data = 32'hFF; ex_data_ok = 1'b0;
    send(32'h10C, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 32'h0, 32'h1234, 32'h22, 32'h0, 32'h22, w);
    chk("zero_no_stall", w, 32'd0);
    chk("zero_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    ex_rd_we = 1'b0; ex_data_ok = 1'b1;
    tick();

    // load-use: stall behind the load here, then behind it in EX, then take MEM data
    send(32'h200, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, w);
    in_valid = 1'b1; in_pc = 32'h204; in_rs1_addr = 5'd0; in_rs2_addr = 5'd3;
    in_rd_addr = 5'd9; in_rd_we = 1'b1; in_is_load = 1'b0; in_imm = 32'h0; rf_rs2 = 32'h999;
    @(negedge clk);
    chk("lu_ready_out", {31'd0, in_ready}, 32'd0);
    chk("lu_cnt0", {16'd0, stall_cnt}, 32'd0);
    tick();
    ex_rd_we = 1'b1; ex_rd = 5'd3; ex_data_ok = 1'b0; ex_data = 32'h0;
    @(negedge clk);
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    chk("lu_cnt1", {16'd0, stall_cnt}, 32'd1);
    chk("lu_ready_ex", {31'd0, in_ready}, 32'd0);
    tick();
    ex_rd_we = 1'b0; mem_rd_we = 1'b1; mem_rd = 5'd3; mem_data = 32'h77;
    q.push_back('{pc: 32'h204, op1: 32'h0, op2: 32'h77, imm: 32'h0, rd: 5'd9, we: 1'b1, ld: 1'b0});
    @(negedge clk);
    chk("lu_cnt2", {16'd0, stall_cnt}, 32'd2);
    chk("lu_ready_mem", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; mem_rd_we = 1'b0;
    tick();

    // backpressure holds the bundle; flush kills it and drops the waiting input
    out_ready = 1'b0;
    send(32'h300, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 32'h8, 32'h11, 32'h22, 32'h11, 32'h22, w);
    in_valid = 1'b1; in_pc = 32'h304; in_rs1_addr = 5'd7; in_rs2_addr = 5'd0;
    in_rd_addr = 5'd0; in_rd_we = 1'b0; rf_rs1 = 32'hAAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_pc", out_pc, 32'h300);
      chk("bp_op1", out_op1, 32'h11);
      tick();
    end
    flush = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_kill", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("flush_drop", {31'd0, out_valid}, 32'd0);
    tick();

    // clock enable low freezes the stage
    clk_en = 1'b0;
    in_valid = 1'b1; in_pc = 32'h400; in_rs1_addr = 5'd1; in_rs2_addr = 5'd2;
    @(negedge clk);
    chk("cen_ready", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("cen_hold_valid", {31'd0, out_valid}, 32'd0);
    chk("cen_hold_cnt", {16'd0, stall_cnt}, 32'd2);
    clk_en = 1'b1; in_valid = 1'b0;
    tick();

    // saturate the stall counter, then reset in the middle of the stall
    out_ready = 1'b0;
    send(32'h500, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 32'h3, 32'h5555, 32'h0, 32'h5555, 32'h0, w);
    in_valid = 1'b1; in_pc = 32'h504; in_rs1_addr = 5'd8; in_rs2_addr = 5'd0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mrst_pc", out_pc, 32'd0);
    chk("mrst_op1", out_op1, 32'd0);
    chk("mrst_imm", out_imm, 32'd0);
    chk("mrst_rd", {27'd0, out_rd_addr}, 32'd0);
    chk("mrst_we_ld", {30'd0, out_rd_we, out_is_load}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clk_en  in  1  global enable; when 0, all state holds.
- in_valid / in_ready  in / out  1 / 1  decode-side handshake.
- in_pc, in_imm  in  32 each  instruction PC and immediate.
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  5 each  source and destination registers.
- in_rd_we, in_is_load  in  1 each  instruction writes rd / instruction is a load.
- rf_rs1_addr, rf_rs2_addr  out  5 each  register-file read addresses.
- rf_rs1, rf_rs2  in  32 each  register-file read data; write-back bypass is already applied.
- ex_rd_we, ex_rd, ex_data, ex_data_ok  in  1/5/32/1  EX-stage result; ex_data_ok is 0 while EX holds a load.
- mem_rd_we, mem_rd, mem_data  in  1/5/32  MEM-stage result; always valid when mem_rd_we=1.
- flush  in  1  kill the instruction held in this stage.
- out_valid / out_ready  out / in  1 / 1  EX-side handshake.
- out_pc, out_op1, out_op2, out_imm  out  32 each  registered operands to EX.
- out_rd_addr, out_rd_we, out_is_load  out  5/1/1  registered destination info.
- stall_cnt  out  16  count of load-use/RAW stall cycles.
REQ-002 Reset SHALL be asynchronous and active-low on rst_n; single clock clk.

Function
REQ-003 rf_rs1_addr / rf_rs2_addr SHALL combinationally equal in_rs1_addr / in_rs2_addr.
REQ-004 The source match term match(r) SHALL be: in_valid & (r != 0) & (r == in_rs1_addr | r == in_rs2_addr).
REQ-005 The stall term SHALL be stall = (out_valid & out_rd_we & match(out_rd_addr)) | (ex_rd_we & !ex_data_ok & match(ex_rd)).
REQ-006 in_ready SHALL be clk_en & !flush & !stall & (out_ready | !out_valid).
REQ-007 Each operand SHALL be selected as follows:
- address 0 gives 32'h0;
- otherwise EX forwarding if ex_rd_we & ex_data_ok & ex_rd == addr;
- otherwise MEM forwarding if mem_rd_we & mem_rd == addr;
- otherwise rf data.
- Priority is EX > MEM > register file.
REQ-008 On clk_en=1 with flush=1, out_valid SHALL become 0 next cycle and the input SHALL be dropped; flush has priority over all other updates.
REQ-009 On clk_en=1 with flush=0 and (out_ready | !out_valid):
- if in_valid & !stall, all out_* fields SHALL capture the selected operands and inputs, and out_valid becomes 1;
- otherwise out_valid becomes 0 (bubble) and the out_* data fields hold.
REQ-010 When out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-011 Capture latency SHALL be 1 cycle: a handshake at edge N presents the operands at cycle N+1.
REQ-012 stall_cnt SHALL increment by 1 on each clk_en cycle with in_valid & stall & !flush, saturating at 16'hFFFF with no wrap.
REQ-013 With clk_en=0, no state SHALL change and in_ready SHALL be 0.

Reset
REQ-014 While rst_n=0, the following SHALL all be 0, asynchronously:
- out_valid, out_rd_we, out_is_load, stall_cnt;
- out_pc, out_op1, out_op2, out_imm, out_rd_addr.
REQ-015 Reset asserted mid-stall or mid-backpressure SHALL discard the held instruction, with no spurious out_valid after release.

Verification
REQ-016 Bench SHALL cover the following scenarios:
- Plain capture: rf_rs1=32'h11, rf_rs2=32'h22, rs1=1, rs2=2, no forwarding -> next cycle out_valid=1, out_op1=32'h11, out_op2=32'h22.
- Priority: ex_rd=mem_rd=5, ex_data=32'hA, mem_data=32'hB, ex_data_ok=1, rs1=5 -> out_op1=32'hA; same with ex_rd_we=0 -> out_op1=32'hB.
- Zero register: rs1=0, ex_rd=0 with ex_rd_we=1, ex_data=32'hFF -> out_op1=32'h0 and no stall.
- Load-use: out holds load rd=3 and in rs2=3 -> in_ready=0, bubble issued, stall_cnt=1. Load then sits in EX with ex_data_ok=0 -> stall again, stall_cnt=2. MEM then supplies mem_data=32'h77 -> capture with out_op2=32'h77.
- Backpressure and flush:
  - out_ready=0 for 3 cycles -> out_* stable and in_ready=0;
  - flush=1 -> out_valid=0 next cycle;
  - flush with in_valid=1 -> instruction dropped.
- Saturation and reset: force 65536 stall cycles -> stall_cnt=16'hFFFF; rst_n low mid-stall -> all outputs 0 immediately.
